// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, flag bit positions and FSM states for alu_datapath_seq
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] FLAG_Z = 2'd0;
  localparam logic [1:0] FLAG_N = 2'd1;
  localparam logic [1:0] FLAG_C = 2'd2;
  localparam logic [1:0] FLAG_V = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_datapath_seq_if.sv
`default_nettype none
// ============================================================================
// alu_datapath_seq_if : control-unit handshake between sequencer and datapath
// Rev 1.0
// ============================================================================
interface alu_datapath_seq_if #(
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic          reg_wr_en;
  logic [AW-1:0] reg_wr_addr;
  logic          op_start;
  logic [2:0]    op_sel;
  logic [AW-1:0] src_a;
  logic [AW-1:0] src_b;
  logic [AW-1:0] dst;
  logic          out_en;
  logic          busy;
  logic          done;
  logic [3:0]    flags;

  modport master (
    output reg_wr_en, reg_wr_addr, op_start, op_sel, src_a, src_b, dst, out_en,
    input  busy, done, flags
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, op_start, op_sel, src_a, src_b, dst, out_en,
    output busy, done, flags
  );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational ALU for opcodes 000-110 with carry and overflow
// Rev 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum   = '0;
    o_res   = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of a zero-extended difference is the unsigned borrow.
        w_sum   = {1'b0, i_a} - {1'b0, i_b};
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_NOT: o_res = ~i_a;
      OP_INC: begin
        w_sum   = {1'b0, i_a} + (WIDTH+1)'(1);
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = ~i_a[WIDTH-1] & w_sum[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_datapath_seq.sv
`default_nettype none
// ============================================================================
// alu_datapath_seq : operand file, sequenced ALU with shift-add multiplier,
//                    status flags and a result register driving the shared bus
// Rev 1.0
// ============================================================================
module alu_datapath_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire [WIDTH-1:0]   bus,
  alu_datapath_seq_if.slave ctl
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_MUL_STEPS = CW'(WIDTH);

  state_e r_state;
  state_e w_next;
  logic   w_busy;

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [AW-1:0]      r_dst;
  logic [WIDTH-1:0]   r_tmp;
  logic               r_tmp_c;
  logic               r_tmp_v;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_done;

  logic [WIDTH-1:0]   w_core_res;
  logic               w_core_c;
  logic               w_core_v;
  logic [WIDTH:0]     w_mac_sum;
  logic [3:0]         w_wb_flags;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_res   (w_core_res),
    .o_carry (w_core_c),
    .o_ovf   (w_core_v)
  );

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (ctl.op_start) begin
          w_next = (ctl.op_sel == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: w_next = S_WB;
      // Steps run while the counter is below WIDTH; one more cycle moves the product out.
      S_MUL:  if (r_cnt == c_MUL_STEPS) w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulator holds {partial product high half, remaining multiplier bits}.
  assign w_mac_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  always_comb begin
    w_wb_flags         = '0;
    w_wb_flags[FLAG_Z] = (r_tmp == '0);
    w_wb_flags[FLAG_N] = r_tmp[WIDTH-1];
    w_wb_flags[FLAG_C] = r_tmp_c;
    w_wb_flags[FLAG_V] = r_tmp_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_dst    <= '0;
      r_tmp    <= '0;
      r_tmp_c  <= 1'b0;
      r_tmp_v  <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_WB);

      if (ctl.reg_wr_en) begin
        r_regs[ctl.reg_wr_addr] <= bus;
      end

      case (r_state)
        S_IDLE: begin
          if (ctl.op_start) begin
            r_a   <= r_regs[ctl.src_a];
            r_b   <= r_regs[ctl.src_b];
            r_op  <= ctl.op_sel;
            r_dst <= ctl.dst;
            r_acc <= {{WIDTH{1'b0}}, r_regs[ctl.src_b]};
            r_cnt <= '0;
          end
        end
        S_EXEC: begin
          r_tmp   <= w_core_res;
          r_tmp_c <= w_core_c;
          r_tmp_v <= w_core_v;
        end
        S_MUL: begin
          if (r_cnt == c_MUL_STEPS) begin
            r_tmp   <= r_acc[WIDTH-1:0];
            r_tmp_c <= |r_acc[2*WIDTH-1:WIDTH];
            r_tmp_v <= 1'b0;
          end else begin
            r_acc <= {w_mac_sum, r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WB: begin
          // Placed after the bus load so a same-edge load to dst loses.
          r_regs[r_dst] <= r_tmp;
          r_result      <= r_tmp;
          r_flags       <= w_wb_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus       = ctl.out_en ? r_result : 'z;
  assign ctl.busy  = w_busy;
  assign ctl.done  = r_done;
  assign ctl.flags = r_flags;

endmodule
`default_nettype wire

// File: doc/alu_datapath_seq.md
# alu_datapath_seq

Parametrised successor to the two-operand ALU datapath: a multi-register operand file loaded from the shared tristate bus, a sequenced ALU with a start/busy/done handshake, a multi-cycle shift-add multiplier, a status-flag register, and a result register that drives the bus on request. It sits on the processor's shared data bus alongside the other bus-attached blocks; the control unit issues register loads and operations and takes the result back over the bus.

## Interface
Parameters:
- WIDTH, 16, data/bus width in bits (≥4)
- NREGS, 4, operand register count (power of two, ≥2); AW = clog2(NREGS)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- bus  inout  WIDTH  shared data bus
- reg_wr_en  in  1  load bus into R[reg_wr_addr] this edge
- reg_wr_addr  in  AW  register-file write address
- op_start  in  1  request operation; sampled only in IDLE
- op_sel  in  3  opcode, sampled with op_start
- src_a, src_b, dst  in  AW each  operand/destination addresses, sampled with op_start
- busy  out  1  high from the edge after accepted op_start until the edge after WB
- done  out  1  one-cycle pulse, cycle after WB
- out_en  in  1  drive result register onto bus
- flags  out  4  {V,C,N,Z}, bits 3..0

## Operation
- Opcodes: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 INC A, 111 MUL (low WIDTH bits of A×B, unsigned).
- FSM states IDLE, EXEC, MUL, WB.
  - IDLE: op_start=1 → latch R[src_a], R[src_b], op_sel, dst; go EXEC (ops 000–110) or MUL (111).
  - EXEC: compute into result temp; → WB.
  - MUL: shift-add over 2·WIDTH accumulator, one multiplier bit per cycle, exactly WIDTH cycles; → WB.
  - WB: write result to R[dst] and result register, update flags; → IDLE; done pulses the following cycle.
- Operands are latched at start; later register writes do not affect an op in flight.
- op_start while not IDLE: ignored, no queueing.
- reg_wr_en accepted in any state; when it targets dst in the WB cycle, the WB write wins.
- bus = result register when out_en=1, else high-Z. out_en together with reg_wr_en copies the result register into a register (legal).
- Flags: Z = result==0; N = result[WIDTH−1]; C = carry-out for ADD/INC, borrow (A<B unsigned) for SUB, OR of product high half for MUL, 0 for logic/NOT; V = signed overflow for ADD/SUB/INC, else 0. Flags hold until the next WB.
- All arithmetic is modulo 2^WIDTH.

## Timing
- Reset: all R[i]=0, result register=0, flags=0, busy=0, done=0, FSM=IDLE, bus high-Z unless out_en=1 (then drives 0).
- Reset mid-operation aborts the op: no WB, no done.
- Single-cycle ops: op_start at edge t → busy high after t, WB at edge t+2, R[dst]/flags valid after t+2, done high during cycle t+2..t+3, busy low after t+2.
- MUL: WB at edge t+WIDTH+2; done one cycle after.
- Back-to-back: a new op_start is accepted on the cycle done is high (FSM already IDLE).
- Register write latency: one edge; the value is readable as an operand on the next op_start.

## Structure
- Shared package alu_pkg: opcode constants, flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3), FSM state enum.
- Sub-module alu_core: combinational WIDTH-parametrised ALU for opcodes 000–110, producing result, carry and overflow. MUL sequencing stays in the top.
- Existing tristate buffer and register cells are reused for the bus driver and operand file.

## Test plan
- Load R0=0x7FFF, R1=0x0001 via bus; ADD dst=R2 → R2=0x8000, flags V=1,N=1,C=0,Z=0; done at t+3.
- SUB R1−R0 (0x0001−0x7FFF) → 0x8002, C=1, N=1; then out_en=1 → bus reads 0x8002; out_en=0 → bus high-Z.
- MUL 0x0100×0x0100 → result 0x0000, Z=1, C=1; busy held exactly WIDTH+2 cycles; op_start mid-MUL ignored.
- INC on 0xFFFF → 0x0000, Z=1, C=1, V=0; simultaneous reg_wr_en to dst in WB cycle → dst holds ALU result.
- rst asserted during MUL → no done, R[dst] unchanged at 0, flags 0, next ADD completes normally.
- Change R[src_a] via bus one cycle after op_start → result uses the original latched value.
